// File: rtl/bicubic_sched_pkg.sv
// Shared types and constants for the bicubic MAC scheduler and its vector unit.
package bicubic_sched_pkg;

    localparam int PIX_W  = 8;
    localparam int WGT_W  = 4;                 // sign-magnitude weight {sign, mag[2:0]}
    localparam int SM_W   = 9;                 // sign-magnitude pixel/intermediate
    localparam int ACC_W  = 16;
    // Weights are in quarter units, so a weight of 4 is unity gain.
    localparam int WSHIFT = 2;

    typedef enum logic [1:0] {IDLE, HPASS, VPASS, OUT} state_t;

    typedef struct packed {
        logic            sign;
        logic [SM_W-2:0] mag;
    } sm_t;

    // {w4,w3,w2,w1} per phase; phase 0 passes tap 2 through unchanged.
    localparam logic [3:0][15:0] WEIGHT_RESET = {16'h9410, 16'h9339, 16'h0149, 16'h0040};

    function automatic int win_idx(input int r, input int c);
        return (r * 4 + c) * PIX_W;
    endfunction

endpackage

// File: rtl/bicubic_vector_mult.sv
// Combinational 4-tap sign-magnitude inner product, scaled and saturated to 8 bits.
module bicubic_vector_mult
    import bicubic_sched_pkg::*;
(
    input  sm_t  [3:0]            pixel,
    input  logic [3:0][WGT_W-1:0] weight,
    output sm_t                   result
);

    logic signed [ACC_W-1:0] acc;
    logic        [ACC_W-1:0] prod;
    logic        [ACC_W-1:0] mag_abs;
    logic        [ACC_W-1:0] mag_q;

    always_comb begin
        acc  = '0;
        prod = '0;
        for (int k = 0; k < 4; k++) begin
            prod = ACC_W'(pixel[k].mag) * ACC_W'(weight[k][WGT_W-2:0]);
            if (pixel[k].sign ^ weight[k][WGT_W-1])
                acc = acc - $signed(prod);
            else
                acc = acc + $signed(prod);
        end
        mag_abs     = acc[ACC_W-1] ? ACC_W'(-acc) : ACC_W'(acc);
        mag_q       = mag_abs >> WSHIFT;
        result.sign = acc[ACC_W-1];
        result.mag  = (mag_q > ACC_W'(255)) ? '1 : mag_q[SM_W-2:0];
    end

endmodule

// File: rtl/bicubic_mac_scheduler.sv
// Runs one separable bicubic interpolation per window through a single shared vector unit:
// four horizontal row passes, one vertical pass, then a clamped pixel held until taken.
module bicubic_mac_scheduler
    import bicubic_sched_pkg::state_t, bicubic_sched_pkg::sm_t, bicubic_sched_pkg::WGT_W,
           bicubic_sched_pkg::WEIGHT_RESET, bicubic_sched_pkg::win_idx;
#(
    parameter int PIX_W  = 8,
    parameter int PHASES = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [16*PIX_W-1:0]        in_window,
    input  logic [$clog2(PHASES)-1:0]  in_phase_x,
    input  logic [$clog2(PHASES)-1:0]  in_phase_y,
    input  logic                       cfg_we,
    input  logic [$clog2(PHASES)-1:0]  cfg_addr,
    input  logic [4*WGT_W-1:0]         cfg_wdata,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [PIX_W-1:0]           out_pixel,
    output logic                       busy
);

    localparam int TBL_W = 4 * WGT_W;

    state_t                       state, state_nx;
    logic [1:0]                   row;
    logic [16*PIX_W-1:0]          win;
    logic [TBL_W-1:0]             wx, wy;
    logic [PHASES-1:0][TBL_W-1:0] wtbl;
    sm_t  [3:0]                   tmp;
    sm_t  [3:0]                   vm_pix;
    logic [3:0][WGT_W-1:0]        vm_wgt;
    sm_t                          vm_res;
    logic                         accept;

    assign in_ready  = (state == bicubic_sched_pkg::IDLE) ||
                       (state == bicubic_sched_pkg::OUT && out_ready);
    assign accept    = in_valid && in_ready;
    assign out_valid = (state == bicubic_sched_pkg::OUT);
    assign busy      = (state != bicubic_sched_pkg::IDLE);

    always_comb begin
        state_nx = state;
        case (state)
            bicubic_sched_pkg::IDLE:  if (accept) state_nx = bicubic_sched_pkg::HPASS;
            bicubic_sched_pkg::HPASS: if (row == 2'd3) state_nx = bicubic_sched_pkg::VPASS;
            bicubic_sched_pkg::VPASS: state_nx = bicubic_sched_pkg::OUT;
            bicubic_sched_pkg::OUT: begin
                if (accept)         state_nx = bicubic_sched_pkg::HPASS;
                else if (out_ready) state_nx = bicubic_sched_pkg::IDLE;
            end
            default:                  state_nx = bicubic_sched_pkg::IDLE;
        endcase
    end

    // Operand mux: the vertical pass reuses the row results, otherwise feed the current row.
    always_comb begin
        vm_pix = '0;
        vm_wgt = '0;
        for (int k = 0; k < 4; k++) begin
            if (state == bicubic_sched_pkg::VPASS) begin
                vm_pix[k] = tmp[k];
                vm_wgt[k] = wy[k*WGT_W +: WGT_W];
            end else begin
                vm_pix[k].sign = 1'b0;
                vm_pix[k].mag  = win[win_idx(int'(row), k) +: PIX_W];
                vm_wgt[k]      = wx[k*WGT_W +: WGT_W];
            end
        end
    end

    bicubic_vector_mult u_vm (
        .pixel  (vm_pix),
        .weight (vm_wgt),
        .result (vm_res)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= bicubic_sched_pkg::IDLE;
            row       <= '0;
            win       <= '0;
            wx        <= '0;
            wy        <= '0;
            tmp       <= '0;
            out_pixel <= '0;
            wtbl      <= WEIGHT_RESET;
        end else begin
            state <= state_nx;
            if (cfg_we)
                wtbl[cfg_addr] <= cfg_wdata;
            // Weights are read with the pre-write table contents on a same-cycle write.
            if (accept) begin
                win <= in_window;
                wx  <= wtbl[in_phase_x];
                wy  <= wtbl[in_phase_y];
                row <= '0;
            end
            if (state == bicubic_sched_pkg::HPASS) begin
                tmp[row] <= vm_res;
                row      <= row + 2'd1;
            end
            if (state == bicubic_sched_pkg::VPASS)
                out_pixel <= vm_res.sign ? '0 : vm_res.mag;
        end
    end

endmodule

// File: tb/tb_bicubic_mac_scheduler.sv
// Directed bench for bicubic_mac_scheduler: vector table plus multi-cycle corner sequences.
module tb_bicubic_mac_scheduler;

    logic         clk = 0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_window;
    logic [1:0]   in_phase_x, in_phase_y;
    logic         cfg_we;
    logic [1:0]   cfg_addr;
    logic [15:0]  cfg_wdata;
    logic         out_valid;
    logic         out_ready;
    logic [7:0]   out_pixel;
    logic         busy;

    int checks = 0;
    int errors = 0;

    logic [15:0] tbl [4];

    typedef struct {
        logic [127:0] win;
        logic [1:0]   px;
        logic [1:0]   py;
        logic [7:0]   exp;
    } vec_t;

    localparam int NV = 8;
    vec_t vecs [NV];

    bicubic_mac_scheduler #(.PIX_W(8), .PHASES(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_window(in_window), .in_phase_x(in_phase_x), .in_phase_y(in_phase_y),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
        .out_valid(out_valid), .out_ready(out_ready), .out_pixel(out_pixel), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [127:0] mk_win(input int base, input int dr, input int dc);
        logic [127:0] w;
        w = '0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                w[(r*4+c)*8 +: 8] = 8'(base + dr*r + dc*c);
        return w;
    endfunction

    // Quarter-unit sign-magnitude inner product, returned as a signed value.
    function automatic int vm_model(input int p0, input int p1, input int p2, input int p3,
                                    input logic [15:0] w);
        int p [4];
        int acc, wt, m;
        p[0] = p0; p[1] = p1; p[2] = p2; p[3] = p3;
        acc = 0;
        for (int k = 0; k < 4; k++) begin
            wt = int'(w[k*4 +: 3]);
            if (w[k*4+3]) wt = -wt;
            acc += p[k] * wt;
        end
        m = ((acc < 0) ? -acc : acc) / 4;
        if (m > 255) m = 255;
        return (acc < 0) ? -m : m;
    endfunction

    function automatic logic [7:0] golden(input logic [127:0] w, input logic [15:0] wx,
                                          input logic [15:0] wy);
        int h [4];
        int v;
        for (int r = 0; r < 4; r++)
            h[r] = vm_model(int'(w[(r*4)*8 +: 8]), int'(w[(r*4+1)*8 +: 8]),
                            int'(w[(r*4+2)*8 +: 8]), int'(w[(r*4+3)*8 +: 8]), wx);
        v = vm_model(h[0], h[1], h[2], h[3], wy);
        return (v < 0) ? 8'd0 : 8'(v);
    endfunction

    task automatic cfg_write(input logic [1:0] a, input logic [15:0] d);
        cfg_we = 1; cfg_addr = a; cfg_wdata = d;
        step();
        cfg_we = 0;
        tbl[a] = d;
    endtask

    task automatic send(input logic [127:0] w, input logic [1:0] px, input logic [1:0] py);
        in_window = w; in_phase_x = px; in_phase_y = py; in_valid = 1;
        step();
        in_valid = 0;
    endtask

    // Counts edges after the accept until out_valid is seen; 5 edges means the OUT cycle is
    // the sixth cycle after the accept.
    task automatic wait_out(output int lat);
        lat = 0;
        while (!out_valid && lat < 20) begin
            step();
            lat++;
        end
    endtask

    task automatic wait_ready(input string name);
        int n;
        n = 0;
        while (!in_ready && n < 20) begin
            step();
            n++;
        end
        chk({name, "_ready"}, 32'(in_ready), 32'd1);
    endtask

    task automatic run_vec(input logic [127:0] w, input logic [1:0] px, input logic [1:0] py,
                           input logic [7:0] exp, input string name);
        int lat;
        wait_ready(name);
        send(w, px, py);
        wait_out(lat);
        chk({name, "_lat"}, 32'(lat), 32'd5);
        chk({name, "_pix"}, 32'(out_pixel), 32'(exp));
        step();
    endtask

    initial begin
        int lat;
        int bad;
        logic [127:0] wneg;
        logic [7:0]   held;

        tbl[0] = 16'h0040; tbl[1] = 16'h0149; tbl[2] = 16'h9339; tbl[3] = 16'h9410;
        rst = 1; in_valid = 0; in_window = '0; in_phase_x = 0; in_phase_y = 0;
        cfg_we = 0; cfg_addr = 0; cfg_wdata = 0; out_ready = 1;
        step(); step();
        rst = 0;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_pixel", 32'(out_pixel), 32'd0);

        // Zero window: in_ready low for the five cycles before OUT.
        send('0, 2'd0, 2'd0);
        bad = 0;
        for (int k = 0; k < 5; k++) begin
            if (in_ready || out_valid) bad++;
            step();
        end
        chk("zero_busy_window", 32'(bad), 32'd0);
        chk("zero_out_valid", 32'(out_valid), 32'd1);
        chk("zero_out_pixel", 32'(out_pixel), 32'd0);
        step();

        cfg_write(2'd2, 16'h9461);
        wneg = '0;
        for (int r = 0; r < 4; r++) wneg[(r*4+3)*8 +: 8] = 8'd200;
        vecs[0] = '{mk_win(0, 0, 0),    2'd0, 2'd0, 8'd0};
        vecs[1] = '{mk_win(100, 0, 0),  2'd0, 2'd0, 8'd100};
        vecs[2] = '{mk_win(5, 16, 10),  2'd0, 2'd0, 8'd31};
        vecs[3] = '{mk_win(200, 0, 0),  2'd2, 2'd2, 8'd255};
        vecs[4] = '{mk_win(5, 16, 10),  2'd3, 2'd0, 8'd36};
        vecs[5] = '{wneg,               2'd2, 2'd0, 8'd0};
        vecs[6] = '{mk_win(5, 16, 10),  2'd2, 2'd2, golden(mk_win(5, 16, 10), tbl[2], tbl[2])};
        vecs[7] = '{mk_win(30, 40, 7),  2'd1, 2'd3, golden(mk_win(30, 40, 7), tbl[1], tbl[3])};
        for (int i = 0; i < NV; i++)
            run_vec(vecs[i].win, vecs[i].px, vecs[i].py, vecs[i].exp, $sformatf("vec%0d", i));

        // Saturated negative rows, then phase-0 vertical: clamps to 0.
        cfg_write(2'd1, 16'hFFFF);
        run_vec(mk_win(255, 0, 0), 2'd1, 2'd0, golden(mk_win(255, 0, 0), tbl[1], tbl[0]), "negclamp_model");
        run_vec(mk_win(255, 0, 0), 2'd1, 2'd0, 8'd0, "negclamp_zero");

        // Backpressure, then release together with a new window.
        out_ready = 0;
        send(mk_win(100, 0, 0), 2'd0, 2'd0);
        wait_out(lat);
        chk("bp_lat", 32'(lat), 32'd5);
        chk("bp_pix", 32'(out_pixel), 32'd100);
        held = out_pixel;
        bad = 0;
        for (int k = 0; k < 10; k++) begin
            step();
            if (out_pixel !== held || in_ready || !out_valid) bad++;
        end
        chk("bp_stall_stable", 32'(bad), 32'd0);
        in_window = mk_win(5, 16, 10); in_phase_x = 0; in_phase_y = 0;
        in_valid = 1; out_ready = 1;
        #1;
        chk("bp_release_ready", 32'(in_ready), 32'd1);
        step();
        in_valid = 0;
        chk("bp_accept_busy", 32'(busy), 32'd1);
        chk("bp_accept_out_valid", 32'(out_valid), 32'd0);
        wait_out(lat);
        chk("bp2_lat", 32'(lat), 32'd5);
        chk("bp2_pix", 32'(out_pixel), 32'd31);
        step();

        // Same-cycle phase-3 write and accept: old weights apply to that window.
        cfg_we = 1; cfg_addr = 2'd3; cfg_wdata = 16'h0040;
        send(mk_win(5, 16, 10), 2'd3, 2'd3);
        cfg_we = 0;
        tbl[3] = 16'h0040;
        wait_out(lat);
        chk("race_lat", 32'(lat), 32'd5);
        chk("race_old_weights", 32'(out_pixel), 32'd44);
        step();
        run_vec(mk_win(5, 16, 10), 2'd3, 2'd3, 8'd31, "race_new_weights");

        // Reset while HPASS is on row 2.
        send(mk_win(100, 0, 0), 2'd2, 2'd2);
        step(); step();
        rst = 1;
        step();
        rst = 0;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_out_valid", 32'(out_valid), 32'd0);
        chk("abort_in_ready", 32'(in_ready), 32'd1);
        chk("abort_out_pixel", 32'(out_pixel), 32'd0);
        bad = 0;
        for (int k = 0; k < 10; k++) begin
            step();
            if (out_valid) bad++;
        end
        chk("abort_no_output", 32'(bad), 32'd0);
        tbl[0] = 16'h0040; tbl[1] = 16'h0149; tbl[2] = 16'h9339; tbl[3] = 16'h9410;
        run_vec(mk_win(100, 0, 0), 2'd2, 2'd2, 8'd100, "abort_tbl2_reset");
        run_vec(mk_win(255, 0, 0), 2'd1, 2'd1, 8'd255, "abort_tbl1_reset");
        run_vec(mk_win(5, 16, 10), 2'd3, 2'd3, 8'd44, "abort_tbl3_reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
